// File: rtl/csa_resolve.sv
// csa_resolve: pipelined resolver that turns a carry-save (sum, carry) pair into binary.
// Each stage adds one SEG-bit segment; results leave in strict FIFO order.
module csa_resolve #(
  parameter int WIDTH = 32,
  parameter int SEG   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_sum,
  input  logic [WIDTH-1:0] in_carry,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_cout
);
  localparam int NSEG = WIDTH / SEG;
  localparam logic [WIDTH-1:0] LOW_MASK = {WIDTH{1'b1}} >> (WIDTH - SEG);

  // Stage k reads index k of each chain and drives index k+1.
  logic [NSEG:0]    valid_chain;
  logic [NSEG:0]    cy_chain;
  logic [WIDTH-1:0] acc_chain [NSEG+1];
  logic [WIDTH-1:0] car_chain [NSEG];
  logic [NSEG-1:0]  en;

  assign valid_chain[0] = in_valid;
  assign cy_chain[0]    = 1'b0;
  assign acc_chain[0]   = in_sum;
  assign car_chain[0]   = in_carry;

  // A stage may advance when it is empty or the stage after it advances.
  always_comb begin
    logic ok;
    en = '0;
    ok = out_ready;
    for (int k = NSEG - 1; k >= 0; k--) begin
      ok    = !valid_chain[k+1] || ok;
      en[k] = ok;
    end
  end

  for (genvar k = 0; k < NSEG; k++) begin : g_stage
    logic [SEG:0]     seg_add;
    logic [WIDTH-1:0] merged;
    logic             v_r;
    logic             cy_r;
    logic [WIDTH-1:0] acc_r;

    assign seg_add = {1'b0, acc_chain[k][SEG-1:0]} + {1'b0, car_chain[k][SEG-1:0]}
                   + {{SEG{1'b0}}, cy_chain[k]};
    assign merged  = (acc_chain[k] & ~LOW_MASK) | WIDTH'(seg_add[SEG-1:0]);

    // The accumulator rotates right by SEG each stage: the next unresolved sum
    // segment sits at the bottom and resolved segments collect from the top.
    always_ff @(posedge clk) begin
      if (rst) begin
        v_r   <= 1'b0;
        cy_r  <= 1'b0;
        acc_r <= '0;
      end else if (en[k]) begin
        v_r   <= valid_chain[k];
        cy_r  <= seg_add[SEG];
        acc_r <= (merged >> SEG) | (merged << (WIDTH - SEG));
      end
    end

    assign valid_chain[k+1] = v_r;
    assign cy_chain[k+1]    = cy_r;
    assign acc_chain[k+1]   = acc_r;

    if (k < NSEG - 1) begin : g_carry
      logic [WIDTH-1:0] car_r;
      always_ff @(posedge clk) begin
        if (rst) begin
          car_r <= '0;
        end else if (en[k]) begin
          car_r <= car_chain[k] >> SEG;
        end
      end
      assign car_chain[k+1] = car_r;
    end
  end

  assign in_ready  = en[0] || rst;
  assign out_valid = valid_chain[NSEG];
  assign out_data  = acc_chain[NSEG];
  assign out_cout  = cy_chain[NSEG];
endmodule

// File: tb/tb_csa_resolve.sv
// tb_csa_resolve: directed and queue-checked tests for csa_resolve at
// WIDTH=16 with SEG=4 (four stages) and SEG=16 (single stage).
module tb_csa_resolve;
  localparam int WIDTH = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid, in_ready, out_valid, out_ready, out_cout;
  logic [WIDTH-1:0] in_sum, in_carry, out_data;
  logic             b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_cout;
  logic [WIDTH-1:0] b_in_sum, b_in_carry, b_out_data;

  int checkCount = 0;
  int errorCount = 0;

  logic [2*WIDTH-1:0] sendQ [$];
  logic [WIDTH:0]     expQ [$];
  logic [2*WIDTH-1:0] sendB [$];
  logic [WIDTH:0]     expB [$];

  always #5 clk = ~clk;

  csa_resolve #(.WIDTH(WIDTH), .SEG(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_sum(in_sum), .in_carry(in_carry),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_cout(out_cout)
  );

  csa_resolve #(.WIDTH(WIDTH), .SEG(WIDTH)) dut_one (
    .clk(clk), .rst(rst),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_sum(b_in_sum), .in_carry(b_in_carry),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data), .out_cout(b_out_cout)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] expected);
    checkCount++;
    if (got !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, expected);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [WIDTH-1:0] s, input logic [WIDTH-1:0] c);
    in_valid = v;
    in_sum   = s;
    in_carry = c;
  endtask

  // One cycle against the four-stage instance, called at a falling edge.
  task automatic runCycle(input logic rdy, input logic offer);
    out_ready = rdy;
    in_valid  = offer && (sendQ.size() > 0);
    if (sendQ.size() > 0) {in_sum, in_carry} = sendQ[0];
    #1;
    if (out_valid && out_ready) begin
      if (expQ.size() == 0) checkOutput("pop_unexpected", 32'(out_valid), 32'd0);
      else checkOutput("pop_data", 32'({out_cout, out_data}), 32'(expQ.pop_front()));
    end
    if (in_valid && in_ready) begin
      expQ.push_back({1'b0, in_sum} + {1'b0, in_carry});
      void'(sendQ.pop_front());
    end
    @(negedge clk);
  endtask

  // One cycle against the single-stage instance.
  task automatic runCycleB(input logic rdy, input logic offer);
    b_out_ready = rdy;
    b_in_valid  = offer && (sendB.size() > 0);
    if (sendB.size() > 0) {b_in_sum, b_in_carry} = sendB[0];
    #1;
    if (b_out_valid && b_out_ready) begin
      if (expB.size() == 0) checkOutput("b_pop_unexpected", 32'(b_out_valid), 32'd0);
      else checkOutput("b_pop_data", 32'({b_out_cout, b_out_data}), 32'(expB.pop_front()));
    end
    if (b_in_valid && b_in_ready) begin
      expB.push_back({1'b0, b_in_sum} + {1'b0, b_in_carry});
      void'(sendB.pop_front());
    end
    @(negedge clk);
  endtask

  logic [WIDTH:0]   exp2 [3] = '{17'h02143, 17'h10000, 17'h00100};
  logic [WIDTH-1:0] sumTab [6] = '{16'hA5A5, 16'h7FFF, 16'hFFFF, 16'h0001, 16'h1357, 16'hFEDC};
  logic [WIDTH-1:0] carTab [6] = '{16'h5A5B, 16'h0001, 16'hFFFF, 16'hFFFF, 16'h2468, 16'h0123};
  logic [WIDTH:0]   held;
  int               cycles;

  initial begin
    rst = 1'b1;
    applyStimulus(1'b0, '0, '0);
    out_ready  = 1'b1;
    b_in_valid = 1'b0; b_in_sum = '0; b_in_carry = '0; b_out_ready = 1'b1;

    // Reset state
    @(negedge clk);
    checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_out_data", 32'(out_data), 32'd0);
    checkOutput("rst_out_cout", 32'(out_cout), 32'd0);
    checkOutput("b_rst_out_valid", 32'(b_out_valid), 32'd0);
    rst = 1'b0;
    #1 checkOutput("post_rst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);

    // Full-width carry ripple, latency 4
    applyStimulus(1'b1, 16'hFFFF, 16'h0001);
    #1 checkOutput("t1_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    applyStimulus(1'b0, '0, '0);
    for (int i = 1; i < 4; i++) begin
      checkOutput($sformatf("t1_lat%0d", i), 32'(out_valid), 32'd0);
      @(negedge clk);
    end
    checkOutput("t1_valid", 32'(out_valid), 32'd1);
    checkOutput("t1_data", 32'(out_data), 32'h0000);
    checkOutput("t1_cout", 32'(out_cout), 32'd1);
    @(negedge clk);
    checkOutput("t1_popped", 32'(out_valid), 32'd0);

    // Back-to-back stream
    applyStimulus(1'b1, 16'h1234, 16'h0F0F);
    @(negedge clk);
    applyStimulus(1'b1, 16'h8000, 16'h8000);
    @(negedge clk);
    applyStimulus(1'b1, 16'h00FF, 16'h0001);
    @(negedge clk);
    applyStimulus(1'b0, '0, '0);
    checkOutput("t2_idle", 32'(out_valid), 32'd0);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("t2_valid%0d", i), 32'(out_valid), 32'd1);
      checkOutput($sformatf("t2_result%0d", i), 32'({out_cout, out_data}), 32'(exp2[i]));
      @(negedge clk);
    end
    checkOutput("t2_drained", 32'(out_valid), 32'd0);

    // Backpressure: six offered, four fit
    for (int i = 0; i < 6; i++) sendQ.push_back({sumTab[i], carTab[i]});
    for (int i = 0; i < 8; i++) runCycle(1'b0, 1'b1);
    checkOutput("t3_accepted", 32'(6 - sendQ.size()), 32'd4);
    in_valid = 1'b1;
    #1 checkOutput("t3_in_ready_full", 32'(in_ready), 32'd0);
    checkOutput("t3_out_valid", 32'(out_valid), 32'd1);
    held = {out_cout, out_data};
    checkOutput("t3_head", 32'(held), 32'({1'b0, sumTab[0]} + {1'b0, carTab[0]}));
    @(negedge clk);
    for (int i = 0; i < 3; i++) runCycle(1'b0, 1'b1);
    checkOutput("t3_held_stable", 32'({out_cout, out_data}), 32'(held));
    cycles = 0;
    while ((sendQ.size() > 0 || expQ.size() > 0) && cycles < 40) begin
      runCycle(1'b1, 1'b1);
      cycles++;
    end
    checkOutput("t3_drain_left", 32'(sendQ.size() + expQ.size()), 32'd0);
    out_ready = 1'b1;
    applyStimulus(1'b0, '0, '0);
    @(negedge clk);

    // Bubble collapse while the head result is stalled
    for (int c = 0; c < 10; c++) begin
      applyStimulus(c == 0 || c == 2, (c == 0) ? 16'h0F0F : 16'hABCD, (c == 0) ? 16'hF0F1 : 16'h1111);
      out_ready = !(c == 4 || c == 5);
      checkOutput($sformatf("t4_valid_c%0d", c), 32'(out_valid), 32'(c >= 4 && c <= 7));
      if (c >= 4 && c <= 6) checkOutput($sformatf("t4_first_c%0d", c), 32'({out_cout, out_data}), 32'h10000);
      if (c == 7) checkOutput("t4_second", 32'({out_cout, out_data}), 32'h0BCDE);
      @(negedge clk);
    end

    // Reset with three results in flight
    for (int c = 0; c < 4; c++) begin
      applyStimulus(c < 3, 16'h1111 * 16'(c + 1), 16'h2222);
      rst = (c == 3);
      @(negedge clk);
    end
    rst = 1'b0;
    checkOutput("t5_out_valid", 32'(out_valid), 32'd0);
    checkOutput("t5_out_data", 32'(out_data), 32'd0);
    checkOutput("t5_out_cout", 32'(out_cout), 32'd0);
    #1 checkOutput("t5_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      checkOutput($sformatf("t5_no_stale%0d", i), 32'(out_valid), 32'd0);
      @(negedge clk);
    end

    // Random traffic on the four-stage instance
    for (int i = 0; i < 1500; i++) sendQ.push_back({16'($urandom), 16'($urandom)});
    cycles = 0;
    while ((sendQ.size() > 0 || expQ.size() > 0) && cycles < 20000) begin
      runCycle($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
      cycles++;
    end
    checkOutput("rand_drain_left", 32'(sendQ.size() + expQ.size()), 32'd0);
    applyStimulus(1'b0, '0, '0);

    // Single-stage instance: boundary pairs, latency 1, then random traffic
    b_in_valid = 1'b1; b_in_sum = 16'hFFFF; b_in_carry = 16'h0001;
    @(negedge clk);
    b_in_valid = 1'b0;
    checkOutput("b_lat1_valid", 32'(b_out_valid), 32'd1);
    checkOutput("b_lat1_result", 32'({b_out_cout, b_out_data}), 32'h10000);
    @(negedge clk);
    sendB.push_back({16'hFFFF, 16'hFFFF});
    sendB.push_back({16'h0000, 16'h0000});
    for (int i = 0; i < 1500; i++) sendB.push_back({16'($urandom), 16'($urandom)});
    cycles = 0;
    while ((sendB.size() > 0 || expB.size() > 0) && cycles < 20000) begin
      runCycleB($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
      cycles++;
    end
    checkOutput("b_rand_drain_left", 32'(sendB.size() + expB.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end
endmodule
